uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10417 (100 MHz / 9600 baud), meaning clock cycles per UART bit.
REQ-002 SHALL have parameter ADDR_W, default 14, meaning instruction-memory word-address width; DEPTH = 2^ADDR_W.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock, rising-edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 SHALL have port rx, input, 1, meaning asynchronous UART serial line, idle high.
REQ-006 SHALL have port prog_we, output, 1, meaning a one-cycle instruction-memory write strobe.
REQ-007 SHALL have port prog_addr, output, ADDR_W, meaning the word address of the current write.
REQ-008 SHALL have port prog_wdata, output, 32, meaning the instruction word to write.
REQ-009 SHALL have port cpu_hold, output, 1, meaning the downstream cpu is held in reset while this is high.
REQ-010 SHALL have port done, output, 1, meaning the load completed successfully.
REQ-011 SHALL have port err, output, 1, meaning a framing error aborted the load.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any other use.
REQ-013 SHALL receive 8N1, LSB first, sampling each bit at CLKS_PER_BIT/2 after its nominal start.
REQ-014 SHALL treat a start bit as false, and return to idle, if rx is high at the start-bit midpoint.
REQ-015 SHALL flag a received byte as a framing error when its stop-bit sample is 0.
REQ-016 SHALL use the frame format: 2 header bytes, word count N big-endian; then N words, 4 bytes each, big-endian (first byte = bits 31:24).
REQ-017 SHALL implement states IDLE_HI -> LEN_LO -> DATA -> DONE, plus ERR.
REQ-018 SHALL transition IDLE_HI -> LEN_LO on a valid byte.
REQ-019 SHALL transition LEN_LO -> DATA when N > 0.
REQ-020 SHALL transition LEN_LO -> DONE when N = 0.
REQ-021 SHALL transition DATA -> DONE after the Nth word.
REQ-022 SHALL transition any receiving state -> ERR on a framing error.
REQ-023 SHALL make DONE and ERR terminal until rst.
REQ-024 SHALL pulse prog_we for exactly 1 cycle, the cycle after the 4th byte of a word is accepted (the stop-bit sample edge).
REQ-025 SHALL hold prog_addr and prog_wdata stable during that prog_we cycle.
REQ-026 SHALL start prog_addr at 0 and increment it by 1 in the cycle after each prog_we.
REQ-027 SHALL suppress prog_we for words with index >= DEPTH while still consuming their bytes and counting them toward N; no address wrap.
REQ-028 SHALL keep cpu_hold = 1 in every state except DONE; it SHALL fall in the same cycle done rises.
REQ-029 SHALL assert done in the cycle after the last prog_we, or the cycle after the LEN_LO byte when N = 0.
REQ-030 SHALL keep done and err mutually exclusive.
REQ-031 SHALL discard the partial word on a framing error mid-word; words already written remain written.
REQ-032 SHALL ignore rx activity once in DONE or ERR.

Reset
REQ-033 SHALL, in the cycle rst is sampled high, set prog_we=0, prog_addr=0, prog_wdata=0, cpu_hold=1, done=0, err=0, state=IDLE_HI, and zero all bit/byte/word counters and synchronizer flops to 1 (idle).
REQ-034 SHALL abort an in-progress load when rst is asserted, restarting at IDLE_HI with no prog_we.

Structure
REQ-035 SHALL place the state encodings, default CLKS_PER_BIT and the frame byte counts in the shared cpu definitions header.
REQ-036 SHALL instantiate one sub-module, uart_rx_byte, containing the synchronizer, bit timing and shift register, and outputting byte_valid (1 cycle), byte_data[7:0] and frame_err.

Verification (CLKS_PER_BIT=16, ADDR_W=4)
REQ-037 SHALL cover: send 00 02, then 12 34 56 78, then 9A BC DE F0 -> prog_we at addr 0 = 0x12345678, at addr 1 = 0x9ABCDEF0, then done=1 and cpu_hold=0.
REQ-038 SHALL cover: send 00 00 -> no prog_we, and done=1 one cycle after the 2nd byte.
REQ-039 SHALL cover: header 00 01, a 2nd data byte with stop bit 0 -> err=1, no prog_we, cpu_hold stays 1.
REQ-040 SHALL cover: header 00 12 (18 words) -> exactly 16 prog_we (addr 0..15), the last 2 words consumed, then done=1.
REQ-041 SHALL cover: a 4-cycle low glitch on idle rx -> no byte accepted, state stays IDLE_HI.
REQ-042 SHALL cover: rst pulsed after the 2nd byte of a word -> outputs at reset values, and a fresh 00 01 AA BB CC DD load writes 0xAABBCCDD to addr 0.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader: state encodings,
// default bit timing and frame byte counts.
package uart_prog_loader_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 10417;
    localparam int HDR_BYTES            = 2;
    localparam int WORD_BYTES           = 4;

    typedef enum logic [2:0] {
        IDLE_HI = 3'd0,
        LEN_LO  = 3'd1,
        DATA    = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, LSB-first shift.
// o_byte_valid / o_frame_err are single-cycle pulses after the stop-bit sample.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err,
    output rx_state_t  o_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic [7:0]       r_data;
    logic             r_ferr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (!r_sync2) r_state <= RX_START;
                end
                RX_START: begin
                    // A line that is high again at mid-start was only a glitch.
                    if (r_cnt == HALF_M1) begin
                        r_cnt   <= '0;
                        r_state <= r_sync2 ? RX_IDLE : RX_BITS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_BITS: begin
                    if (r_cnt == BIT_M1) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == BIT_M1) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            r_valid <= 1'b1;
                            r_data  <= r_shift;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_byte_valid = r_valid;
    assign o_byte_data  = r_data;
    assign o_frame_err  = r_ferr;
    assign o_state      = r_state;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a length-prefixed stream of big-endian 32-bit words from a UART into
// instruction memory, holding the cpu in reset until the load completes.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [31:0]       prog_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output state_t            o_state,
    output rx_state_t         o_rx_state
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [1:0]        LAST_BYTE = 2'(WORD_BYTES - 1);

    logic        w_byte_valid;
    logic [7:0]  w_byte_data;
    logic        w_frame_err;
    logic        w_in_range;
    logic [31:0] w_word;

    state_t            r_state;
    logic [15:0]       r_count;
    logic [15:0]       r_words;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_shift;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic              r_done;
    logic              r_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_byte_valid(w_byte_valid),
        .o_byte_data (w_byte_data),
        .o_frame_err (w_frame_err),
        .o_state     (o_rx_state)
    );

    // Words past the end of memory are still consumed but never written.
    assign w_in_range = (32'(r_words) < 32'(DEPTH));
    assign w_word     = {r_shift, w_byte_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE_HI;
            r_count    <= '0;
            r_words    <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_we && r_addr != ADDR_MAX) r_addr <= r_addr + 1'b1;
            case (r_state)
                IDLE_HI: begin
                    if (w_frame_err) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end else if (w_byte_valid) begin
                        r_count[15:8] <= w_byte_data;
                        r_state       <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_frame_err) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end else if (w_byte_valid) begin
                        r_count[7:0] <= w_byte_data;
                        if ({r_count[15:8], w_byte_data} == 16'd0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    // Completion is seen the cycle after the last word, so done trails prog_we by one.
                    if (r_words == r_count) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_hold  <= 1'b0;
                    end else if (w_frame_err) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end else if (w_byte_valid) begin
                        r_shift <= {r_shift[15:0], w_byte_data};
                        if (r_byte_idx == LAST_BYTE) begin
                            r_byte_idx <= '0;
                            r_words    <= r_words + 1'b1;
                            if (w_in_range) begin
                                r_we    <= 1'b1;
                                r_wdata <= w_word;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end
                end
                DONE, ERR: ;
                default: begin
                    r_state <= ERR;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign prog_we    = r_we;
    assign prog_addr  = r_addr;
    assign prog_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign err        = r_err;
    assign o_state    = r_state;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed and randomized loads driven over the serial line, checked against
// a frame-level model of the expected memory writes and final status.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int CPB   = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    state_t        o_state;
    rx_state_t     o_rx_state;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .o_state   (o_state),
        .o_rx_state(o_rx_state)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [35:0] exp_q[$];
    logic [35:0] obs_q[$];
    logic [7:0]  tx_bytes[$];
    bit          tx_stop[$];
    bit          exp_done, exp_err, exp_tight;

    bit   mon_en = 0;
    int   bad_excl = 0, bad_hold = 0, bad_we = 0;
    int   last_we_cyc = -1, done_rise_cyc = -1, stop_start_cyc = 0;
    logic we_q = 1'b0, done_q = 1'b0;

    // Observe writes and per-cycle invariants between clock edges.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prog_we === 1'b1) begin
                obs_q.push_back({prog_addr, prog_wdata});
                last_we_cyc = cyc;
                if (we_q) bad_we++;
            end
            if (done === 1'b1 && err === 1'b1) bad_excl++;
            if (cpu_hold !== ~done) bad_hold++;
            if (done === 1'b1 && !done_q) done_rise_cyc = cyc;
        end
        we_q   = (prog_we === 1'b1);
        done_q = (done === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        bad_excl = 0; bad_hold = 0; bad_we = 0;
        last_we_cyc = -1; done_rise_cyc = -1;
        mon_en = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        stop_start_cyc = cyc;
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic q_byte(input logic [7:0] b, input bit ok);
        tx_bytes.push_back(b);
        tx_stop.push_back(ok);
    endtask

    task automatic send_all();
        for (int i = 0; i < tx_bytes.size(); i++) send_byte(tx_bytes[i], tx_stop[i]);
    endtask

    // Frame-level view: header gives N, every complete 4-byte group is word w.
    function automatic void model();
        int          n;
        int          w;
        logic [31:0] word;
        n = -1;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        for (int i = 0; i < tx_bytes.size(); i++) begin
            if (exp_done || exp_err) break;
            if (!tx_stop[i]) begin
                exp_err = 1;
                break;
            end
            if (i == 1) begin
                n = int'(tx_bytes[0]) * 256 + int'(tx_bytes[1]);
                if (n == 0) exp_done = 1;
            end else if (i >= 2 && ((i - 2) % 4) == 3) begin
                w    = (i - 2) / 4;
                word = {tx_bytes[i-3], tx_bytes[i-2], tx_bytes[i-1], tx_bytes[i]};
                if (w < DEPTH) exp_q.push_back({4'(w), word});
                if (w + 1 == n) exp_done = 1;
            end
        end
        exp_tight = exp_done && n > 0 && n <= DEPTH;
    endfunction

    task automatic run_check(input string name);
        int nmin;
        model();
        for (int i = 0; i < 64 && !(done === 1'b1 || err === 1'b1); i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({name, " done"}, 64'(done), 64'(exp_done));
        check({name, " err"}, 64'(err), 64'(exp_err));
        check({name, " cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
        check({name, " write_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) check({name, " write"}, 64'(obs_q[i]), 64'(exp_q[i]));
        check({name, " done_err_excl"}, 64'(bad_excl), 64'd0);
        check({name, " hold_vs_done"}, 64'(bad_hold), 64'd0);
        check({name, " we_one_cycle"}, 64'(bad_we), 64'd0);
        if (exp_tight) check({name, " done_after_last_we"}, 64'(done_rise_cyc), 64'(last_we_cyc + 1));
    endtask

    initial begin
        int n;
        int bad;
        int total;

        do_reset();
        check("reset prog_we", 64'(prog_we), 64'd0);
        check("reset prog_addr", 64'(prog_addr), 64'd0);
        check("reset prog_wdata", 64'(prog_wdata), 64'd0);
        check("reset cpu_hold", 64'(cpu_hold), 64'd1);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset state", 64'(o_state), 64'(IDLE_HI));

        // Two-word load, with trailing bytes that must be ignored after DONE.
        do_reset();
        tx_bytes.delete(); tx_stop.delete();
        q_byte(8'h00, 1); q_byte(8'h02, 1);
        q_byte(8'h12, 1); q_byte(8'h34, 1); q_byte(8'h56, 1); q_byte(8'h78, 1);
        q_byte(8'h9A, 1); q_byte(8'hBC, 1); q_byte(8'hDE, 1); q_byte(8'hF0, 1);
        q_byte(8'h55, 1); q_byte(8'h66, 1);
        send_all();
        run_check("two_words");
        check("two_words word0", 64'(exp_q[0]), 64'({4'd0, 32'h12345678}));

        // Zero-length load.
        do_reset();
        tx_bytes.delete(); tx_stop.delete();
        q_byte(8'h00, 1); q_byte(8'h00, 1);
        send_all();
        run_check("zero_len");
        n = done_rise_cyc - stop_start_cyc;
        check("zero_len done_latency", 64'(n >= CPB / 2 && n <= CPB / 2 + 8), 64'd1);

        // Framing error on the second data byte, followed by bytes to ignore.
        do_reset();
        tx_bytes.delete(); tx_stop.delete();
        q_byte(8'h00, 1); q_byte(8'h01, 1);
        q_byte(8'h11, 1); q_byte(8'h22, 0); q_byte(8'h33, 1); q_byte(8'h44, 1);
        send_all();
        run_check("frame_err");
        check("frame_err state", 64'(o_state), 64'(ERR));

        // 18 words into 16-word memory.
        do_reset();
        tx_bytes.delete(); tx_stop.delete();
        q_byte(8'h00, 1); q_byte(8'h12, 1);
        for (int i = 0; i < 18 * 4; i++) q_byte(8'($urandom_range(0, 255)), 1);
        send_all();
        run_check("overflow");
        check("overflow writes", 64'(obs_q.size()), 64'd16);

        // Short low glitch on the idle line, then a real load must still parse.
        do_reset();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch state", 64'(o_state), 64'(IDLE_HI));
        check("glitch no_write", 64'(obs_q.size()), 64'd0);
        tx_bytes.delete(); tx_stop.delete();
        q_byte(8'h00, 1); q_byte(8'h01, 1);
        q_byte(8'hCA, 1); q_byte(8'hFE, 1); q_byte(8'hF0, 1); q_byte(8'h0D, 1);
        send_all();
        run_check("after_glitch");

        // Reset in the middle of a word, then a fresh load.
        do_reset();
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'h11, 1); send_byte(8'h22, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst prog_we", 64'(prog_we), 64'd0);
        check("midrst prog_addr", 64'(prog_addr), 64'd0);
        check("midrst cpu_hold", 64'(cpu_hold), 64'd1);
        check("midrst done", 64'(done), 64'd0);
        check("midrst err", 64'(err), 64'd0);
        check("midrst state", 64'(o_state), 64'(IDLE_HI));
        rst = 1'b0;
        @(negedge clk);
        obs_q.delete();
        tx_bytes.delete(); tx_stop.delete();
        q_byte(8'h00, 1); q_byte(8'h01, 1);
        q_byte(8'hAA, 1); q_byte(8'hBB, 1); q_byte(8'hCC, 1); q_byte(8'hDD, 1);
        send_all();
        run_check("after_rst");

        // Randomized short loads, sometimes with one corrupted stop bit.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            tx_bytes.delete(); tx_stop.delete();
            n = $urandom_range(1, 4);
            total = 2 + 4 * n;
            bad = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, total - 1)) : -1;
            q_byte(8'h00, bad != 0);
            q_byte(8'(n), bad != 1);
            for (int i = 2; i < total; i++) q_byte(8'($urandom_range(0, 255)), bad != i);
            send_all();
            run_check("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
